// File: rtl/axi_transaction_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi_transaction
// Purpose : Shared AXI write-channel payload types and master count.
// Rev     : 1.0  initial release
// ============================================================================
package axi_transaction;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam int n_masters = 2;

endpackage
`default_nettype wire

// File: rtl/axi_resp_order_fifo.sv
`default_nettype none
// ============================================================================
// Module  : axi_resp_order_fifo
// Purpose : In-order FIFO of granted master indices used to route B responses.
// Rev     : 1.0  initial release
// ============================================================================
module axi_resp_order_fifo #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          head
);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_write_arbiter
// Purpose : Round-robin two-master AW/W arbiter with in-order B routing.
// Rev     : 1.0  initial release
// ============================================================================
module axi_write_arbiter
    import axi_transaction::*;
#(
    parameter int B_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  addr_t [n_masters-1:0]   m_awaddr,
    input  logic  [n_masters-1:0]   m_awvalid,
    output logic  [n_masters-1:0]   m_awready,
    input  data_t [n_masters-1:0]   m_wdata,
    input  logic  [n_masters-1:0]   m_wvalid,
    output logic  [n_masters-1:0]   m_wready,
    output logic  [n_masters-1:0]   m_bvalid,
    input  logic  [n_masters-1:0]   m_bready,
    output addr_t                   s_awaddr,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output data_t                   s_wdata,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    output logic                    b_unexpected
);

    localparam int CW = $clog2(B_DEPTH + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]           r_state;
    logic                 r_grant;
    logic                 r_rr_next;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic                 r_b_unexpected;

    logic [n_masters-1:0] w_req;
    logic                 w_busy;
    logic                 w_grant_sel;
    logic                 w_aw_fin;
    logic                 w_w_fin;
    logic                 w_complete;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic                 w_head;

    assign w_req       = m_awvalid | m_wvalid;
    assign w_busy      = (r_state == c_BUSY);
    assign w_grant_sel = (&w_req) ? r_rr_next : w_req[1];

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_awaddr  = m_awaddr[r_grant];
        s_wdata   = m_wdata[r_grant];
        if (w_busy) begin
            s_awvalid          = m_awvalid[r_grant] & ~r_aw_done;
            s_wvalid           = m_wvalid[r_grant] & ~r_w_done;
            m_awready[r_grant] = s_awready & ~r_aw_done;
            m_wready[r_grant]  = s_wready & ~r_w_done;
        end
        if (w_count != '0) begin
            m_bvalid[w_head] = s_bvalid;
            s_bready         = m_bready[w_head];
        end
    end

    // A channel counts as done if it finished earlier or handshakes this cycle.
    assign w_aw_fin   = r_aw_done | (s_awvalid & s_awready);
    assign w_w_fin    = r_w_done | (s_wvalid & s_wready);
    assign w_complete = w_busy & w_aw_fin & w_w_fin;
    assign w_pop      = s_bvalid & s_bready;

    axi_resp_order_fifo #(
        .DEPTH (B_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_complete),
        .push_data (r_grant),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_grant        <= 1'b0;
            r_rr_next      <= 1'b0;
            r_aw_done      <= 1'b0;
            r_w_done       <= 1'b0;
            r_b_unexpected <= 1'b0;
        end else begin
            if (w_empty && s_bvalid) begin
                r_b_unexpected <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if ((|w_req) && !w_full) begin
                        r_grant   <= w_grant_sel;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (w_complete) begin
                        r_rr_next <= ~r_grant;
                        r_state   <= c_IDLE;
                    end else begin
                        r_aw_done <= w_aw_fin;
                        r_w_done  <= w_w_fin;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign b_unexpected = r_b_unexpected;

endmodule
`default_nettype wire

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Two-master write-channel arbiter in front of one simplified AXI slave (AW, W, B channels; no response code, no write ID). It grants one master at a time, forwards that master's AW and W handshakes to the slave, and records each completed grant in an in-order response FIFO so slave `bvalid` pulses return to the correct master. Read channels (AR/R) bypass this block.

## Interface
- `B_DEPTH`, default 4: maximum writes issued whose B response is still pending; power of two, ≥ 2.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous reset, active-high.
- `m_awaddr` in 2×`addr_t`: per-master write address, index 0/1.
- `m_awvalid` in 2, `m_awready` out 2: per-master AW handshake.
- `m_wdata` in 2×`data_t`, `m_wvalid` in 2, `m_wready` out 2: per-master W channel.
- `m_bvalid` out 2, `m_bready` in 2: per-master B channel.
- `s_awaddr` out `addr_t`, `s_awvalid` out 1, `s_awready` in 1: slave AW channel.
- `s_wdata` out `data_t`, `s_wvalid` out 1, `s_wready` in 1: slave W channel.
- `s_bvalid` in 1, `s_bready` out 1: slave B channel.
- `b_unexpected` out 1: sticky; set when `s_bvalid`=1 while the response FIFO is empty.

## Operation
- FSM states: IDLE, BUSY. Registers: `grant` (1 bit), `rr_next` (1 bit), `aw_done`, `w_done`, response FIFO of master indices, `count` (0..B_DEPTH).
- IDLE: master i requests if `m_awvalid[i] | m_wvalid[i]`. If any master requests and `count < B_DEPTH`, load `grant`, clear `aw_done`/`w_done`, go to BUSY. Both requesting: `grant = rr_next`. One requesting: that master wins.
- IDLE outputs: all `m_awready`, `m_wready`, `s_awvalid`, `s_wvalid` = 0.
- BUSY forwarding, combinational, with g = `grant`:
  - `s_awvalid = m_awvalid[g] & ~aw_done`, `s_awaddr = m_awaddr[g]`, `m_awready[g] = s_awready & ~aw_done`.
  - W channel follows the same rule using `w_done`.
  - The non-granted master sees ready = 0.
- Channel completion: an AW handshake sets `aw_done`; a W handshake sets `w_done`. AW and W can complete in either order or in the same cycle.
- Transaction complete: the cycle in which both channels are done, counting handshakes in that cycle. At the next edge the block pushes g into the FIFO, sets `rr_next = ~g`, and returns to IDLE.
- B routing, driven from the FIFO head h when `count > 0`:
  - `m_bvalid[h] = s_bvalid`; `s_bready = m_bready[h]`; the other master's `m_bvalid` = 0.
  - Pop on `s_bvalid & s_bready`.
- FIFO empty: `s_bready` = 0 and both `m_bvalid` = 0. If `s_bvalid` = 1 in this state, set `b_unexpected`.
- Push and pop in the same cycle: `count` is unchanged; the pointers advance.
- Overflow cannot occur: the grant is gated by `count < B_DEPTH`, and at most one transaction is in flight.

## Timing
- Reset: on an edge with `rst` = 1, state → IDLE; `grant`, `rr_next`, `aw_done`, `w_done` = 0; FIFO pointers and `count` = 0; `b_unexpected` = 0.
- Every output is 0 from that edge until the next grant. `s_awaddr`/`s_wdata` mirror master 0.
- Reset mid-transaction drops the grant and discards pending responses.
- Latency: a request first seen in IDLE at cycle t is granted at edge t+1. The earliest slave handshake is in cycle t+1.
- Minimum issue interval is 2 cycles per write: one BUSY cycle plus one IDLE cycle.
- B path is zero-latency combinational in both directions. No combinational path exists from master valids to master readies except through slave readies.
- `rr_next` updates only at transaction completion, never at grant.

## Structure
- `addr_t` and `data_t` come from the shared `axi_transaction` package. Add `localparam n_masters = 2` there.
- One natural sub-module: `axi_resp_order_fifo`, a synchronous FIFO with parameter `DEPTH`, 1-bit data, push/pop inputs, `full`/`empty`/`count` outputs, and a combinational head.
- Round-robin and FSM logic stay in the top module.

## Test plan
- Single write: master 0 asserts AW `0x10` and W `0xAB` at cycle 0, slave always ready → slave handshakes at cycle 1 with addr `0x10`, data `0xAB`. Slave `bvalid` at cycle 3 → `m_bvalid[0]` = 1, `m_bvalid[1]` = 0, pop.
- Contention: both masters request every cycle → grants alternate 0,1,0,1. Four B responses are routed in the order 0,1,0,1.
- Split channels, master 1: AW is accepted at cycle 1 with W held low until cycle 4 → `s_awvalid` = 0 after cycle 1. Completion is at cycle 4. IDLE at cycle 5.
- FIFO full, `B_DEPTH` = 4, slave `bvalid` held 0: four writes complete and the fifth request is stalled in IDLE. One B pop → the fifth request is granted at the next edge.
- Reset while BUSY with `aw_done` = 1: all outputs 0 at the next edge and `count` = 0. A subsequent `s_bvalid` sets `b_unexpected`.
- Simultaneous push and pop with `count` = 2 → `count` stays 2. Routing order is preserved.
